// File: rtl/phy_pkg.sv
// Shared PHY datapath definitions: width-select encoding and word geometry.
package phy_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned NB_W   = 3;

  localparam logic [1:0] PCLK_W32  = 2'b00;
  localparam logic [1:0] PCLK_W16  = 2'b01;
  localparam logic [1:0] PCLK_W8   = 2'b10;
  localparam logic [1:0] PCLK_W32B = 2'b11;

  // Bytes per word for a given width select.
  function automatic logic [NB_W-1:0] pclk_bytes(input logic [1:0] pclk);
    logic [NB_W-1:0] n;
    case (pclk)
      PCLK_W16: n = NB_W'(2);
      PCLK_W8:  n = NB_W'(1);
      default:  n = NB_W'(4);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/recibidor_width_dec.sv
// Maps the PCLK width select to a byte count and the matching byte-lane mask.
module recibidor_width_dec
  import phy_pkg::*;
(
  input  logic [1:0]       pclk_i,
  output logic [NB_W-1:0]  nbytes_o,
  output logic [LANES-1:0] lane_mask_o
);

  always_comb begin
    nbytes_o = pclk_bytes(pclk_i);
    case (nbytes_o)
      NB_W'(1): lane_mask_o = 4'b0001;
      NB_W'(2): lane_mask_o = 4'b0011;
      default:  lane_mask_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/recibidor_8_32.sv
// Byte-to-word deserializer: collects MSB-first bytes into 32/16/8-bit words.
module recibidor_8_32
  import phy_pkg::*;
#(
  parameter bit ZERO_ON_DISABLE = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              ENB,
  input  logic [1:0]        PCLK,
  input  logic [BYTE_W-1:0] in_8,
  input  logic              valid_in,
  output logic [WORD_W-1:0] out_32,
  output logic              valid_out,
  output logic              busy
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NB_W-1:0]   n_q, n_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [NB_W-1:0]   dec_n;
  logic [LANES-1:0]  dec_mask;
  logic [NB_W-1:0]   n_c;
  logic [LANES-1:0]  mask_c;
  logic [CNT_W-1:0]  last_idx_c;
  logic [CNT_W-1:0]  lane_c;
  logic [WORD_W-1:0] word_c;
  logic [WORD_W-1:0] mask32_c;

  recibidor_width_dec u_width_dec (
    .pclk_i      (PCLK),
    .nbytes_o    (dec_n),
    .lane_mask_o (dec_mask)
  );

  // Width is sampled only at word start; the accumulator is zero whenever cnt_q is zero.
  always_comb begin
    n_c        = (cnt_q == '0) ? dec_n : n_q;
    mask_c     = (cnt_q == '0) ? dec_mask : mask_q;
    last_idx_c = CNT_W'(n_c - NB_W'(1));
    lane_c     = last_idx_c - cnt_q;
    word_c     = acc_q | (WORD_W'(in_8) << {lane_c, 3'b000});
    mask32_c   = {{BYTE_W{mask_c[3]}}, {BYTE_W{mask_c[2]}},
                  {BYTE_W{mask_c[1]}}, {BYTE_W{mask_c[0]}}};
  end

  always_comb begin
    cnt_d   = cnt_q;
    n_d     = n_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = 1'b0;
    if (!ENB) begin
      cnt_d = '0;
      acc_d = '0;
      if (ZERO_ON_DISABLE) out_d = '0;
    end else if (valid_in) begin
      n_d    = n_c;
      mask_d = mask_c;
      if (cnt_q == last_idx_c) begin
        out_d   = word_c & mask32_c;
        valid_d = 1'b1;
        cnt_d   = '0;
        acc_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = word_c;
      end
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt_q   <= '0;
      n_q     <= NB_W'(4);
      mask_q  <= 4'b1111;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign out_32    = out_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_recibidor_8_32.sv
// Directed bench for recibidor_8_32 with hand-computed expected words.
module tb_recibidor_8_32;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        enb;
  logic [1:0]  pclk;
  logic [7:0]  in_8;
  logic        valid_in;
  logic [31:0] out_32;
  logic        valid_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  recibidor_8_32 dut (
    .CLK       (clk),
    .RESET_L   (rst_l),
    .ENB       (enb),
    .PCLK      (pclk),
    .in_8      (in_8),
    .valid_in  (valid_in),
    .out_32    (out_32),
    .valid_out (valid_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then sample just after it.
  task automatic step(input logic e, input logic v, input logic [7:0] b);
    @(negedge clk);
    enb      = e;
    valid_in = v;
    in_8     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic vo, input logic bz, input logic [31:0] w);
    chk({tag, ".valid"}, 32'(vo), 32'(valid_out));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".out"}, out_32, w);
  endtask

  initial begin
    rst_l    = 1'b0;
    enb      = 1'b0;
    pclk     = 2'b00;
    in_8     = 8'h00;
    valid_in = 1'b0;
    #12;
    chk("rst.out", out_32, 32'h0);
    chk("rst.valid", 32'(valid_out), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    rst_l = 1'b1;

    // 32-bit word
    pclk = 2'b00;
    step(1, 1, 8'hDE); expect_out("w32.b0", 0, 1, 32'h0);
    step(1, 1, 8'hAD); expect_out("w32.b1", 0, 1, 32'h0);
    step(1, 1, 8'hBE); expect_out("w32.b2", 0, 1, 32'h0);
    step(1, 1, 8'hEF); expect_out("w32.b3", 1, 0, 32'hDEADBEEF);
    step(1, 0, 8'h00); expect_out("w32.idle", 0, 0, 32'hDEADBEEF);

    // 16-bit back-to-back words
    pclk = 2'b01;
    step(1, 1, 8'h12); expect_out("w16.b0", 0, 1, 32'hDEADBEEF);
    step(1, 1, 8'h34); expect_out("w16.b1", 1, 0, 32'h00001234);
    step(1, 1, 8'h56); expect_out("w16.b2", 0, 1, 32'h00001234);
    step(1, 1, 8'h78); expect_out("w16.b3", 1, 0, 32'h00005678);

    // 8-bit word, with a gap
    pclk = 2'b10;
    step(1, 0, 8'hFF); expect_out("w8.gap", 0, 0, 32'h00005678);
    step(1, 1, 8'hA5); expect_out("w8.b0", 1, 0, 32'h000000A5);

    // Width change mid-word is ignored until the next word start
    pclk = 2'b00;
    step(1, 1, 8'h11); expect_out("hold.b0", 0, 1, 32'h000000A5);
    step(1, 1, 8'h22); expect_out("hold.b1", 0, 1, 32'h000000A5);
    pclk = 2'b10;
    step(1, 1, 8'h33); expect_out("hold.b2", 0, 1, 32'h000000A5);
    step(1, 0, 8'h99); expect_out("hold.gap", 0, 1, 32'h000000A5);
    step(1, 1, 8'h44); expect_out("hold.b3", 1, 0, 32'h11223344);
    step(1, 1, 8'h55); expect_out("hold.next", 1, 0, 32'h00000055);

    // Disable mid-word discards the partial word
    pclk = 2'b00;
    step(1, 1, 8'h01); expect_out("dis.b0", 0, 1, 32'h00000055);
    step(1, 1, 8'h02); expect_out("dis.b1", 0, 1, 32'h00000055);
    step(0, 1, 8'h03); expect_out("dis.off", 0, 0, 32'h0);
    step(1, 1, 8'hCA); expect_out("dis.b0n", 0, 1, 32'h0);
    step(1, 1, 8'hFE); expect_out("dis.b1n", 0, 1, 32'h0);
    step(1, 1, 8'hBA); expect_out("dis.b2n", 0, 1, 32'h0);
    step(1, 1, 8'hBE); expect_out("dis.b3n", 1, 0, 32'hCAFEBABE);

    // Asynchronous reset mid-word
    step(1, 1, 8'hAA); expect_out("rst2.b0", 0, 1, 32'hCAFEBABE);
    step(1, 1, 8'hBB); expect_out("rst2.b1", 0, 1, 32'hCAFEBABE);
    rst_l = 1'b0;
    #2;
    expect_out("rst2.async", 0, 0, 32'h0);
    #1;
    rst_l = 1'b1;
    step(1, 1, 8'h01); expect_out("rst2.n0", 0, 1, 32'h0);
    step(1, 1, 8'h23); expect_out("rst2.n1", 0, 1, 32'h0);
    step(1, 1, 8'h45); expect_out("rst2.n2", 0, 1, 32'h0);
    step(1, 1, 8'h67); expect_out("rst2.n3", 1, 0, 32'h01234567);
    step(1, 0, 8'h00); expect_out("rst2.idle", 0, 0, 32'h01234567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
